// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator. Each channel divides clk by its
// own runtime divisor in periodic or one-shot mode, with glitch-free retuning.
module tick_gen_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 100000,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              sync_clr,
  output logic [N_CH-1:0]   o_tick,
  output logic [N_CH-1:0]   o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   sh_div_q, sh_div_d;
    logic               mode_q, mode_d;
    logic               sh_mode_q, sh_mode_d;
    logic               pend_q, pend_d;
    logic               tick_q, tick_d;
    logic               wr;
    logic [CNT_W-1:0]   last_cnt;
    logic               term;

    // Out-of-range channel numbers never match any gi, so those writes are dropped.
    assign wr       = cfg_we && (cfg_ch == CH_W'(gi));
    assign last_cnt = (div_q == '0) ? '0 : div_q - CNT_W'(1);
    assign term     = (cnt_q >= last_cnt);

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      mode_d    = mode_q;
      sh_div_d  = sh_div_q;
      sh_mode_d = sh_mode_q;
      pend_d    = pend_q;
      tick_d    = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (wr) begin
            div_d  = cfg_div;
            mode_d = cfg_mode;
            pend_d = 1'b0;
          end
          if (ch_en[gi]) state_d = RUN;
        end
        RUN: begin
          // While running, writes are parked so the current period is never disturbed.
          if (wr) begin
            sh_div_d  = cfg_div;
            sh_mode_d = cfg_mode;
            pend_d    = 1'b1;
          end
          if (!ch_en[gi]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (sync_clr) begin
            cnt_d = '0;
          end else if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (wr) begin
              div_d  = cfg_div;
              mode_d = cfg_mode;
              pend_d = 1'b0;
            end else if (pend_q) begin
              div_d  = sh_div_q;
              mode_d = sh_mode_q;
              pend_d = 1'b0;
            end
            if (mode_q) state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          cnt_d = '0;
          if (wr) begin
            div_d  = cfg_div;
            mode_d = cfg_mode;
            pend_d = 1'b0;
          end
          if (!ch_en[gi]) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        div_q     <= CNT_W'(DEF_DIV);
        mode_q    <= 1'b0;
        sh_div_q  <= CNT_W'(DEF_DIV);
        sh_mode_q <= 1'b0;
        pend_q    <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        div_q     <= div_d;
        mode_q    <= mode_d;
        sh_div_q  <= sh_div_d;
        sh_mode_q <= sh_mode_d;
        pend_q    <= pend_d;
        tick_q    <= tick_d;
      end
    end

    assign o_tick[gi] = tick_q;
    assign o_busy[gi] = (state_q == RUN);
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: absolute-time tick schedule model checked every
// cycle, plus directed literal checks of the key tick positions.
module tb_tick_gen_multi;
  localparam int N     = 5;
  localparam int CNT_W = 32;
  localparam int DEF   = 10;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     ch_en = '0;
  logic             cfg_we = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_mode = 1'b0;
  logic             sync_clr = 1'b0;
  logic [N-1:0]     o_tick;
  logic [N-1:0]     o_busy;

  tick_gen_multi #(.N_CH(N), .CNT_W(CNT_W), .DEF_DIV(DEF), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .sync_clr(sync_clr),
    .o_tick(o_tick), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_pass = 0;
  bit     started = 1'b0;
  longint t = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", nm, t, act, exp);
  endtask

  // Model: each running channel holds the absolute edge number of its next tick.
  int       st [N];
  longint   nt [N], dv [N], sdv [N];
  bit       md [N], smd [N], pnd [N];
  logic [N-1:0] exp_tick = '0, exp_busy = '0;

  function automatic longint eff(longint d);
    return (d == 0) ? 64'd1 : d;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit wr, tk, om;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        st[c] = 0; dv[c] = DEF; sdv[c] = DEF; md[c] = 0; smd[c] = 0; pnd[c] = 0; nt[c] = 0;
      end
      exp_tick = '0;
      exp_busy = '0;
    end else begin
      t++;
      for (int c = 0; c < N; c++) begin
        wr = cfg_we && (int'(cfg_ch) == c);
        tk = 1'b0;
        if (st[c] == 0) begin
          if (wr) begin dv[c] = cfg_div; md[c] = cfg_mode; pnd[c] = 0; end
          if (ch_en[c]) begin st[c] = 1; nt[c] = t + eff(dv[c]); end
        end else if (st[c] == 1) begin
          if (!ch_en[c]) begin
            st[c] = 0;
            if (wr) begin sdv[c] = cfg_div; smd[c] = cfg_mode; pnd[c] = 1; end
          end else if (sync_clr) begin
            nt[c] = t + eff(dv[c]);
            if (wr) begin sdv[c] = cfg_div; smd[c] = cfg_mode; pnd[c] = 1; end
          end else if (t == nt[c]) begin
            tk = 1'b1;
            om = md[c];
            if (wr) begin dv[c] = cfg_div; md[c] = cfg_mode; pnd[c] = 0; end
            else if (pnd[c]) begin dv[c] = sdv[c]; md[c] = smd[c]; pnd[c] = 0; end
            if (om) st[c] = 2;
            else nt[c] = t + eff(dv[c]);
          end else if (wr) begin
            sdv[c] = cfg_div; smd[c] = cfg_mode; pnd[c] = 1;
          end
        end else begin
          if (wr) begin dv[c] = cfg_div; md[c] = cfg_mode; pnd[c] = 0; end
          if (!ch_en[c]) st[c] = 0;
        end
        exp_tick[c] = tk;
        exp_busy[c] = (st[c] == 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && started) begin
      chk("model_tick", 32'(o_tick), 32'(exp_tick));
      chk("model_busy", 32'(o_busy), 32'(exp_busy));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic goto(longint n);
    while (t < n) @(negedge clk);
  endtask

  task automatic cfg(int ch, longint d, bit m);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(d); cfg_mode = m;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    longint e, w;
    repeat (3) @(negedge clk);
    chk("rst_tick", 32'(o_tick), 0);
    chk("rst_busy", 32'(o_busy), 0);
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);

    // Default divisor on ch0: ticks at +10, +20, +30.
    ch_en[0] = 1'b1; e = t + 1;
    for (int k = 1; k <= 30; k++) begin
      goto(e + k);
      chk("A_tick0", 32'(o_tick[0]), 32'(k % 10 == 0));
    end
    chk("A_busy0", 32'(o_busy[0]), 1);
    ch_en[0] = 1'b0;
    @(negedge clk);

    // ch1: D=0 behaves as D=1, then retune while running.
    cfg(1, 0, 1'b0);
    ch_en[1] = 1'b1; e = t + 1;
    for (int k = 1; k <= 3; k++) begin
      goto(e + k);
      chk("B_d0_tick1", 32'(o_tick[1]), 1);
    end
    cfg(1, 1, 1'b0);
    chk("B_d1_tick1", 32'(o_tick[1]), 1);
    w = t + 1;
    cfg(1, 3, 1'b0);
    chk("B_w3_tick1", 32'(o_tick[1]), 1);
    goto(w + 2); chk("B_gap_tick1", 32'(o_tick[1]), 0);
    goto(w + 3); chk("B_p3_tick1", 32'(o_tick[1]), 1);
    goto(w + 4);
    cfg(1, 5, 1'b0);
    chk("B_shadow_tick1", 32'(o_tick[1]), 0);
    goto(w + 6); chk("B_keep_tick1", 32'(o_tick[1]), 1);
    goto(w + 10); chk("B_p5gap_tick1", 32'(o_tick[1]), 0);
    goto(w + 11); chk("B_p5_tick1", 32'(o_tick[1]), 1);
    ch_en[1] = 1'b0;
    @(negedge clk);

    // ch2 one-shot D=5, then re-arm.
    cfg(2, 5, 1'b1);
    ch_en[2] = 1'b1; e = t + 1;
    for (int k = 1; k <= 12; k++) begin
      goto(e + k);
      chk("C_tick2", 32'(o_tick[2]), 32'(k == 5));
      if (k == 4) chk("C_busy2_run", 32'(o_busy[2]), 1);
    end
    chk("C_busy2_done", 32'(o_busy[2]), 0);
    ch_en[2] = 1'b0;
    @(negedge clk);
    ch_en[2] = 1'b1; e = t + 1;
    for (int k = 1; k <= 7; k++) begin
      goto(e + k);
      chk("C_rearm_tick2", 32'(o_tick[2]), 32'(k == 5));
    end
    ch_en[2] = 1'b0;
    @(negedge clk);

    // ch0 D=4 and ch3 D=6, sync_clr on ch0's terminal edge.
    cfg(0, 4, 1'b0);
    cfg(3, 6, 1'b0);
    ch_en[0] = 1'b1; ch_en[3] = 1'b1; e = t + 1;
    goto(e + 4); chk("D_tick0_4", 32'(o_tick[0]), 1);
    goto(e + 6); chk("D_tick3_6", 32'(o_tick[3]), 1);
    goto(e + 7);
    sync_clr = 1'b1;
    goto(e + 8);
    sync_clr = 1'b0;
    chk("D_sync_tick", 32'({o_tick[3], o_tick[0]}), 0);
    goto(e + 12); chk("D_tick0_12", 32'({o_tick[3], o_tick[0]}), 32'b01);
    goto(e + 14); chk("D_tick3_14", 32'(o_tick[3]), 1);

    // Write on ch0's terminal edge, then an out-of-range channel write.
    goto(e + 15);
    cfg(0, 7, 1'b0);
    chk("E_term_tick0", 32'(o_tick[0]), 1);
    cfg(5, 2, 1'b1);
    goto(e + 22); chk("E_gap_tick0", 32'(o_tick[0]), 0);
    cfg(3, 9, 1'b0);
    chk("E_p7_tick0", 32'(o_tick[0]), 1);

    // Async reset while ch0 tick is high and ch3 has a pending write.
    #2 rst = 1'b1;
    #1;
    chk("F_rst_tick", 32'(o_tick), 0);
    chk("F_rst_busy", 32'(o_busy), 0);
    ch_en = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ch_en[3] = 1'b1; e = t + 1;
    for (int k = 1; k <= 20; k++) begin
      goto(e + k);
      chk("F_def_tick3", 32'(o_tick[3]), 32'(k % 10 == 0));
    end
    chk("F_busy3", 32'(o_busy[3]), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
